// File: rtl/sram_byte_arbiter.sv
// Byte-wide SRAM port arbiter: video linear read bursts (priority) and CPU 16-bit byte-split accesses.
// Optional macro SRAM_ARB_STARVE_GUARD_EN grants the CPU after STARVE_LIMIT back-to-back video grants.
module sram_byte_arbiter #(
  parameter int ADDR_W       = 21,
  parameter int VID_BURST    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_sram,
  input  logic              rst,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [7:0]        vid_data,
  output logic              vid_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [1:0]        cpu_be,
  input  logic [15:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic [15:0]       cpu_rdata,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_WE_n,
  output logic [7:0]        sram_dout,
  output logic              sram_doe,
  input  logic [7:0]        sram_din,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, VID_RD, CPU_RD, CPU_WSET, CPU_WSTB, CPU_WHLD, CPU_DONE} state_t;

  state_t            r_state, w_state;
  logic [ADDR_W-1:0] r_addr, w_addr, r_base, w_base;
  logic              r_we_n, w_we_n, r_doe, w_doe;
  logic [7:0]        r_dout, w_dout, r_wd_hi, w_wd_hi;
  logic              r_be_hi, w_be_hi, r_hi, w_hi;
  logic [6:0]        r_cnt, w_cnt;
  logic              r_vid_ack, w_vid_ack, r_cpu_ack, w_cpu_ack;
  logic              r_vid_valid;
  logic [7:0]        r_vid_data, r_rlo;
  logic [15:0]       r_cpu_rdata;
  logic              w_starved;

`ifdef SRAM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] r_starve;
  // Counts video grants that overtook a waiting CPU; any other grant clears it.
  always_ff @(posedge clk_sram) begin
    if (rst)
      r_starve <= '0;
    else if (r_state == IDLE && w_state != IDLE)
      r_starve <= (w_state == VID_RD && cpu_req) ? r_starve + SW'(1) : '0;
  end
  assign w_starved = cpu_req && (r_starve >= SW'(STARVE_LIMIT));
`else
  assign w_starved = 1'b0;
`endif

  always_comb begin
    w_state   = r_state;
    w_addr    = r_addr;
    w_we_n    = 1'b1;
    w_doe     = 1'b0;
    w_dout    = r_dout;
    w_base    = r_base;
    w_wd_hi   = r_wd_hi;
    w_be_hi   = r_be_hi;
    w_hi      = r_hi;
    w_cnt     = r_cnt;
    w_vid_ack = 1'b0;
    w_cpu_ack = 1'b0;
    case (r_state)
      IDLE: begin
        if (vid_req && !w_starved) begin
          w_state   = VID_RD;
          w_addr    = vid_addr;
          w_cnt     = '0;
          w_vid_ack = 1'b1;
        end else if (cpu_req) begin
          w_base  = cpu_addr;
          w_wd_hi = cpu_wdata[15:8];
          w_be_hi = cpu_be[1];
          w_cnt   = '0;
          if (!cpu_we) begin
            w_state = CPU_RD;
            w_addr  = cpu_addr;
          end else if (cpu_be[0]) begin
            w_state = CPU_WSET;
            w_addr  = cpu_addr;
            w_dout  = cpu_wdata[7:0];
            w_doe   = 1'b1;
            w_hi    = 1'b0;
          end else if (cpu_be[1]) begin
            w_state = CPU_WSET;
            w_addr  = cpu_addr + ADDR_W'(1);
            w_dout  = cpu_wdata[15:8];
            w_doe   = 1'b1;
            w_hi    = 1'b1;
          end else begin
            w_state   = CPU_DONE;
            w_cpu_ack = 1'b1;
          end
        end
      end
      VID_RD: begin
        if (r_cnt == 7'(VID_BURST - 1)) begin
          w_state = IDLE;
        end else begin
          w_cnt  = r_cnt + 7'd1;
          w_addr = r_addr + ADDR_W'(1);
        end
      end
      CPU_RD: begin
        if (r_cnt == 7'd0) begin
          w_cnt  = 7'd1;
          w_addr = r_addr + ADDR_W'(1);
        end else begin
          w_state   = IDLE;
          w_cpu_ack = 1'b1;
        end
      end
      CPU_WSET: begin
        w_state = CPU_WSTB;
        w_we_n  = 1'b0;
        w_doe   = 1'b1;
      end
      CPU_WSTB: begin
        w_state = CPU_WHLD;
        w_doe   = 1'b1;
      end
      CPU_WHLD: begin
        if (!r_hi && r_be_hi) begin
          w_state = CPU_WSET;
          w_addr  = r_base + ADDR_W'(1);
          w_dout  = r_wd_hi;
          w_doe   = 1'b1;
          w_hi    = 1'b1;
        end else begin
          w_state   = CPU_DONE;
          w_cpu_ack = 1'b1;
        end
      end
      CPU_DONE: w_state = IDLE;
      default:  w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_sram) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_we_n      <= 1'b1;
      r_doe       <= 1'b0;
      r_dout      <= '0;
      r_base      <= '0;
      r_wd_hi     <= '0;
      r_be_hi     <= 1'b0;
      r_hi        <= 1'b0;
      r_cnt       <= '0;
      r_vid_ack   <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_vid_valid <= 1'b0;
      r_vid_data  <= '0;
      r_rlo       <= '0;
      r_cpu_rdata <= '0;
    end else begin
      r_state     <= w_state;
      r_addr      <= w_addr;
      r_we_n      <= w_we_n;
      r_doe       <= w_doe;
      r_dout      <= w_dout;
      r_base      <= w_base;
      r_wd_hi     <= w_wd_hi;
      r_be_hi     <= w_be_hi;
      r_hi        <= w_hi;
      r_cnt       <= w_cnt;
      r_vid_ack   <= w_vid_ack;
      r_cpu_ack   <= w_cpu_ack;
      // Read data is captured at the edge closing the cycle its address was on the bus.
      r_vid_valid <= (r_state == VID_RD);
      if (r_state == VID_RD) r_vid_data <= sram_din;
      if (r_state == CPU_RD) begin
        if (r_cnt == 7'd0) r_rlo <= sram_din;
        else               r_cpu_rdata <= {sram_din, r_rlo};
      end
    end
  end

  assign SRAM_ADDR = r_addr;
  assign SRAM_WE_n = r_we_n;
  assign sram_dout = r_dout;
  assign sram_doe  = r_doe;
  assign vid_ack   = r_vid_ack;
  assign vid_valid = r_vid_valid;
  assign vid_data  = r_vid_data;
  assign cpu_ack   = r_cpu_ack;
  assign cpu_rdata = r_cpu_rdata;
  assign busy      = (r_state != IDLE);
endmodule

// File: tb/tb_sram_byte_arbiter.sv
// Scoreboard bench for sram_byte_arbiter: SRAM model, reference memory, directed and random traffic.
module tb_sram_byte_arbiter;
  localparam int AW = 21;
  localparam int VB = 8;

  logic          clk_sram = 1'b0;
  logic          rst = 1'b1;
  logic          vid_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] vid_addr = '0, cpu_addr = '0;
  logic [1:0]    cpu_be = '0;
  logic [15:0]   cpu_wdata = '0;
  logic          vid_ack, vid_valid, cpu_ack, SRAM_WE_n, sram_doe, busy;
  logic [7:0]    vid_data, sram_dout;
  logic [7:0]    sram_din = '0;
  logic [15:0]   cpu_rdata;
  logic [AW-1:0] SRAM_ADDR;

  always #5 clk_sram = ~clk_sram;

  sram_byte_arbiter #(.ADDR_W(AW), .VID_BURST(VB), .STARVE_LIMIT(4)) dut (
    .clk_sram(clk_sram), .rst(rst),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data), .vid_valid(vid_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_n(SRAM_WE_n), .sram_dout(sram_dout), .sram_doe(sram_doe),
    .sram_din(sram_din), .busy(busy)
  );

  // SRAM contents (model of the chip) and reference contents (what the bench expects).
  logic [7:0] mem     [logic [AW-1:0]];
  logic [7:0] ref_mem [logic [AW-1:0]];

  function automatic logic [7:0] pat(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction
  function automatic logic [7:0] mem_rd(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : pat(a);
  endfunction
  function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pat(a);
  endfunction

  always @(negedge clk_sram) sram_din = mem_rd(SRAM_ADDR);
  always @(posedge clk_sram) if (!SRAM_WE_n && sram_doe) mem[SRAM_ADDR] = sram_dout;

  int vectors = 0, miscompares = 0;
  int we_pulses = 0;
  logic prev_we_low = 1'b0, prev_doe = 1'b0;

  typedef struct {logic rd; logic [15:0] d;} cexp_t;
  logic [7:0] vid_q [$];
  cexp_t      cpu_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response, and checks strobe framing.
  cexp_t ce;
  logic [7:0] ve;
  always @(negedge clk_sram) begin
    if (vid_valid) begin
      if (vid_q.size() == 0) chk("vid_valid_extra", 32'(vid_valid), 0);
      else begin ve = vid_q.pop_front(); chk("vid_data", 32'(vid_data), 32'(ve)); end
    end
    if (cpu_ack) begin
      if (cpu_q.size() == 0) chk("cpu_ack_extra", 32'(cpu_ack), 0);
      else begin
        ce = cpu_q.pop_front();
        if (ce.rd) chk("cpu_rdata", 32'(cpu_rdata), 32'(ce.d));
      end
    end
    if (!SRAM_WE_n) begin
      we_pulses++;
      chk("doe_during_we", 32'(sram_doe), 1);
      chk("doe_before_we", 32'(prev_doe), 1);
    end
    if (prev_we_low && !rst) chk("doe_after_we", 32'(sram_doe), 1);
    prev_we_low = !SRAM_WE_n;
    prev_doe    = sram_doe;
  end

  task automatic wait_idle();
    for (int n = 0; n < 200; n++) begin
      @(negedge clk_sram);
      if (!busy && vid_q.size() == 0 && cpu_q.size() == 0) return;
    end
    chk("idle_timeout", 32'(vid_q.size() + cpu_q.size()) + 32'(busy), 0);
    vid_q.delete();
    cpu_q.delete();
  endtask

  task automatic push_burst(input logic [AW-1:0] a);
    logic [AW-1:0] ai;
    for (int i = 0; i < VB; i++) begin
      ai = a + AW'(i);
      vid_q.push_back(ref_rd(ai));
    end
  endtask

  task automatic do_vid(input logic [AW-1:0] a, output int acks);
    bit got = 0;
    acks = 0;
    @(negedge clk_sram);
    vid_addr = a; vid_req = 1'b1;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk_sram);
      if (vid_ack) begin push_burst(a); vid_req = 1'b0; acks++; got = 1; end
    end
    if (!got) begin chk("vid_ack_timeout", 32'(vid_ack), 1); vid_req = 1'b0; end
    for (int n = 0; n < VB + 2; n++) begin
      @(negedge clk_sram);
      if (vid_ack) acks++;
    end
    wait_idle();
  endtask

  task automatic do_cpu(input logic we, input logic [AW-1:0] a, input logic [1:0] be,
                        input logic [15:0] wd, output int lat, output int pulses);
    logic [AW-1:0] a1;
    int p0;
    bit got = 0;
    a1 = a + AW'(1);
    if (!we) cpu_q.push_back('{1'b1, {ref_rd(a1), ref_rd(a)}});
    else begin
      if (be[0]) ref_mem[a]  = wd[7:0];
      if (be[1]) ref_mem[a1] = wd[15:8];
      cpu_q.push_back('{1'b0, 16'h0});
    end
    @(negedge clk_sram);
    p0 = we_pulses;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_be = be; cpu_wdata = wd;
    lat = 0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk_sram);
      lat++;
      if (cpu_ack) got = 1;
    end
    cpu_req = 1'b0;
    if (!got) chk("cpu_ack_timeout", 32'(cpu_ack), 1);
    pulses = we_pulses - p0;
    wait_idle();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, pulses, acks, nb, r;
    logic [AW-1:0] a;
    logic [1:0] be;
    logic [15:0] wd;
    bit got;

    // Reset and idle
    repeat (3) @(negedge clk_sram);
    chk("rst_we_n", 32'(SRAM_WE_n), 1);
    chk("rst_doe", 32'(sram_doe), 0);
    chk("rst_addr", 32'(SRAM_ADDR), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dout", 32'(sram_dout), 0);
    chk("rst_pulses", {29'd0, vid_ack, vid_valid, cpu_ack}, 0);
    chk("rst_rdata", 32'(cpu_rdata), 0);
    chk("rst_vdata", 32'(vid_data), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk_sram);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_we_n", 32'(SRAM_WE_n), 1);

    // Wrapping video burst over preloaded bytes
    for (int k = 0; k < VB; k++) begin
      a = AW'(21'h1FFFFE) + AW'(k);
      mem[a] = 8'h10 + 8'(k);
      ref_mem[a] = 8'h10 + 8'(k);
    end
    do_vid(21'h1FFFFE, acks);
    chk("vid_wrap_acks", 32'(acks), 1);

    // Full word write, then read back
    do_cpu(1'b1, 21'h100, 2'b11, 16'hBEEF, lat, pulses);
    chk("wr11_lat", 32'(lat), 7);
    chk("wr11_pulses", 32'(pulses), 2);
    chk("wr11_lo", 32'(mem_rd(21'h100)), 32'h EF);
    chk("wr11_hi", 32'(mem_rd(21'h101)), 32'h BE);
    do_cpu(1'b0, 21'h100, 2'b00, 16'h0, lat, pulses);
    chk("rd_lat", 32'(lat), 3);
    chk("rd_pulses", 32'(pulses), 0);

    // High byte only, then no bytes
    do_cpu(1'b1, 21'h200, 2'b10, 16'h55AA, lat, pulses);
    chk("wr10_pulses", 32'(pulses), 1);
    chk("wr10_hi", 32'(mem_rd(21'h201)), 32'h55);
    chk("wr10_lo_kept", 32'(mem_rd(21'h200)), 32'(pat(21'h200)));
    do_cpu(1'b1, 21'h300, 2'b00, 16'h1234, lat, pulses);
    chk("wr00_lat", 32'(lat), 1);
    chk("wr00_pulses", 32'(pulses), 0);

    // Simultaneous requests: burst, one idle cycle, then the CPU read
    fork
      do_vid(21'h050, acks);
      do_cpu(1'b0, 21'h100, 2'b11, 16'h0, lat, pulses);
    join
    chk("simul_cpu_lat", 32'(lat), 12);
    chk("simul_vid_acks", 32'(acks), 1);

`ifdef SRAM_ARB_STARVE_GUARD_EN
    // Video held high: CPU must get in after the 4th burst
    cpu_q.push_back('{1'b1, {ref_rd(21'h101), ref_rd(21'h100)}});
    @(negedge clk_sram);
    vid_addr = 21'h080; vid_req = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 21'h100; cpu_be = 2'b11;
    nb = 0; got = 0;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk_sram);
      if (vid_ack) begin push_burst(21'h080); nb++; end
      if (cpu_ack) got = 1;
    end
    cpu_req = 1'b0; vid_req = 1'b0;
    chk("starve_ack", 32'(got), 1);
    chk("starve_bursts", 32'(nb), 4);
    wait_idle();
`endif

    // Reset during the write strobe aborts the transaction
    @(negedge clk_sram);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 21'h400; cpu_be = 2'b11; cpu_wdata = 16'h1234;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk_sram);
      if (!SRAM_WE_n) got = 1;
    end
    chk("abort_saw_we", 32'(got), 1);
    rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk_sram);
    chk("abort_we_n", 32'(SRAM_WE_n), 1);
    chk("abort_doe", 32'(sram_doe), 0);
    chk("abort_busy", 32'(busy), 0);
    @(negedge clk_sram);
    rst = 1'b0;
    ref_mem[21'h400] = 8'h34;
    repeat (10) @(negedge clk_sram);
    chk("abort_idle", 32'(busy), 0);

    // Random traffic in a window that straddles the address wrap
    for (int it = 0; it < 40; it++) begin
      r  = int'($urandom_range(0, 3));
      a  = AW'(21'h1FFFF0) + AW'($urandom_range(0, 31));
      be = 2'($urandom_range(0, 3));
      wd = 16'($urandom);
      if (r == 0) begin
        do_vid(a, acks);
        chk("rnd_vid_acks", 32'(acks), 1);
      end else if (r == 1) begin
        do_cpu(1'b0, a, be, wd, lat, pulses);
        chk("rnd_rd_pulses", 32'(pulses), 0);
      end else begin
        do_cpu(1'b1, a, be, wd, lat, pulses);
        chk("rnd_wr_pulses", 32'(pulses), 32'(be[0]) + 32'(be[1]));
      end
    end

    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
